// File: rtl/seg_scan_ctrl.sv
// ----------------------------------------------------------------------------
// seg_scan_ctrl
//
// Time-multiplexed scan controller for a 4-digit common-anode seven-segment
// display. Each digit is lit for SCAN_DIV cycles, followed by GUARD_CYC
// all-off cycles that suppress ghosting. Frames are double-buffered. A load
// lands in the shadow buffer and is promoted to the active buffer only at a
// frame end, so the display never shows a partial update. Per-digit blink
// toggles every BLINK_FRAMES full frames.
//
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   load       single-cycle strobe, captures data/dp/blank/blink
//   data[15:0] hex nibble per digit, data[4d+3:4d] -> digit d
//   dp[3:0]    decimal point enable per digit (1 = lit)
//   blank[3:0] per-digit blank (1 = dark)
//   blink[3:0] per-digit blink enable (1 = dark in the blink-off phase)
//   sel[3:0]   active-low one-hot digit select
//   lout[7:0]  active-low segments, bits 7..1 = a..g, bit 0 = dp
//   pending    shadow buffer holds a frame not yet applied
//   frame_tick one-cycle pulse on the last cycle of each frame
// ----------------------------------------------------------------------------
module seg_scan_ctrl #(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD_CYC    = 2,
  parameter int BLINK_FRAMES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  input  logic [3:0]  blink,
  output logic [3:0]  sel,
  output logic [7:0]  lout,
  output logic        pending,
  output logic        frame_tick
);

  localparam logic [0:0] ST_SHOW  = 1'b0;
  localparam logic [0:0] ST_GUARD = 1'b1;

  localparam int CNT_MAX = (SCAN_DIV > GUARD_CYC) ? SCAN_DIV : GUARD_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int FRM_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYC > 0) ? GUARD_CYC - 1 : 0);
  localparam logic [FRM_W-1:0] FRM_LAST   = FRM_W'(BLINK_FRAMES - 1);
  localparam bit               HAS_GUARD  = (GUARD_CYC > 0);

  // Scan FSM state
  logic [0:0]       state, state_nx;
  logic [1:0]       digit, digit_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             frame_end;

  // Blink timing
  logic [FRM_W-1:0] frm_cnt;
  logic             blink_on;

  // Active and shadow frame buffers
  logic [15:0] act_data, shd_data;
  logic [3:0]  act_dp, shd_dp;
  logic [3:0]  act_blank, shd_blank;
  logic [3:0]  act_blink, shd_blink;
  logic        pend_q;

  // Registered display outputs
  logic [3:0] sel_p1;
  logic [7:0] lout_p1;
  logic       frame_tick_p1;

  // Active-low a..g pattern for one hex nibble.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  // Last cycle of digit 3's slot. Without a guard gap the slot ends on the
  // final SHOW cycle instead of the final GUARD cycle.
  function automatic logic is_last(input logic [0:0]       st,
                                   input logic [1:0]       dg,
                                   input logic [CNT_W-1:0] ct);
    logic r;
    if (HAS_GUARD)
      r = (dg == 2'd3) && (st == ST_GUARD) && (ct == GUARD_LAST);
    else
      r = (dg == 2'd3) && (st == ST_SHOW) && (ct == SHOW_LAST);
    return r;
  endfunction

  assign frame_end = is_last(state, digit, cnt);

  always_comb begin
    state_nx = state;
    digit_nx = digit;
    cnt_nx   = cnt + CNT_W'(1);
    if (state == ST_SHOW) begin
      if (cnt == SHOW_LAST) begin
        cnt_nx = '0;
        if (HAS_GUARD) begin
          state_nx = ST_GUARD;
        end else begin
          digit_nx = digit + 2'd1;
        end
      end
    end else begin
      if (cnt == GUARD_LAST) begin
        cnt_nx   = '0;
        state_nx = ST_SHOW;
        digit_nx = digit + 2'd1;
      end
    end
  end

  // Stage p0 -> p1: scan FSM advance; frame_tick is registered from the
  // next state so it lines up with the frame-end FSM cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_SHOW;
      digit         <= 2'd0;
      cnt           <= '0;
      frame_tick_p1 <= 1'b0;
    end else begin
      state         <= state_nx;
      digit         <= digit_nx;
      cnt           <= cnt_nx;
      frame_tick_p1 <= is_last(state_nx, digit_nx, cnt_nx);
    end
  end

  // A load on the frame-end cycle bypasses the shadow and goes straight to
  // the active buffer; otherwise a pending shadow frame is promoted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shd_data  <= 16'h0000;
      shd_dp    <= 4'h0;
      shd_blank <= 4'hF;
      shd_blink <= 4'h0;
      act_data  <= 16'h0000;
      act_dp    <= 4'h0;
      act_blank <= 4'hF;
      act_blink <= 4'h0;
      pend_q    <= 1'b0;
    end else begin
      if (load) begin
        shd_data  <= data;
        shd_dp    <= dp;
        shd_blank <= blank;
        shd_blink <= blink;
      end
      if (frame_end) begin
        pend_q <= 1'b0;
        if (load) begin
          act_data  <= data;
          act_dp    <= dp;
          act_blank <= blank;
          act_blink <= blink;
        end else if (pend_q) begin
          act_data  <= shd_data;
          act_dp    <= shd_dp;
          act_blank <= shd_blank;
          act_blink <= shd_blink;
        end
      end else if (load) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Frame counter wraps at BLINK_FRAMES-1, so each blink half-period spans
  // exactly BLINK_FRAMES frames.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_cnt  <= '0;
      blink_on <= 1'b1;
    end else if (frame_end) begin
      if (frm_cnt == FRM_LAST) begin
        frm_cnt  <= '0;
        blink_on <= ~blink_on;
      end else begin
        frm_cnt <= frm_cnt + FRM_W'(1);
      end
    end
  end

  logic [3:0] cur_nib;
  logic       cur_dark;

  assign cur_nib  = act_data[{digit, 2'b00} +: 4];
  assign cur_dark = act_blank[digit] | (act_blink[digit] & ~blink_on);

  // Stage p0 -> p1: segment decode and digit select register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_p1  <= 4'hF;
      lout_p1 <= 8'hFF;
    end else if ((state == ST_SHOW) && !cur_dark) begin
      sel_p1  <= ~(4'b0001 << digit);
      lout_p1 <= {seg7(cur_nib), ~act_dp[digit]};
    end else begin
      sel_p1  <= 4'hF;
      lout_p1 <= 8'hFF;
    end
  end

  assign sel        = sel_p1;
  assign lout       = lout_p1;
  assign pending    = pend_q;
  assign frame_tick = frame_tick_p1;

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Scan controller that time-multiplexes the board's 4-digit common-anode seven-segment display. It holds a double-buffered 4-digit hex frame with per-digit decimal point, blank and blink controls, and steps through the digits with a programmable dwell and an inter-digit guard (all-off) gap to suppress ghosting. New frames are loaded at any time but applied only at a frame boundary, so the display never tears. It drives the display-facing digit-select and segment buses directly.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is lit (SHOW state); must be >= 1
GUARD_CYC, 2, clock cycles of all-off between digits (GUARD state); 0 means no guard
BLINK_FRAMES, 128, full frames per blink half-period; must be >= 1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  single-cycle strobe; captures data/dp/blank/blink into the shadow buffer
data  in  16  four hex nibbles; data[4d+3:4d] is the value for digit d
dp  in  4  decimal point enable per digit, 1 = lit
blank  in  4  per-digit blank, 1 = digit dark
blink  in  4  per-digit blink enable, 1 = digit goes dark in the blink-off phase
sel  out  4  digit select, active-low one-hot; sel[d] = 0 lights digit d
lout  out  8  segments, active-low; bits 7..1 = a..g, bit 0 = dp
pending  out  1  shadow buffer holds a frame not yet applied
frame_tick  out  1  one-cycle pulse on the last cycle of each frame

Behaviour:
- Reset (asynchronous, rst_n=0): sel=4'b1111, lout=8'hFF, pending=0, frame_tick=0. Digit index d=0, state SHOW, dwell counter 0, frame counter 0, blink phase = on. Active and shadow buffers: data=0, dp=0, blank=4'b1111 (display dark until the first load), blink=0.
- FSM SHOW: lasts exactly SCAN_DIV cycles, then goes to GUARD. If GUARD_CYC=0, it goes directly to SHOW for the next digit.
- FSM GUARD: lasts exactly GUARD_CYC cycles, then goes to SHOW with d=(d+1) mod 4 (wraps 3 -> 0).
- Slot length is SCAN_DIV+GUARD_CYC cycles. Frame length is 4 slots.
- Frame end is the last cycle of digit 3's slot. frame_tick=1 in that cycle only.
- Outputs are registered: sel and lout reflect the FSM state with 1-cycle latency.
- SHOW output when the digit is visible: sel=~(4'b0001<<d); lout[7:1]=hex pattern of active nibble d; lout[0]=~dp[d].
- The digit is dark in SHOW when blank[d]=1, or when blink[d]=1 and the blink phase is off. A dark digit gives sel=4'b1111 and lout=8'hFF.
- GUARD output: sel=4'b1111, lout=8'hFF.
- Hex patterns for lout[7:1]:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- Load:
  - load=1 captures all four inputs into the shadow buffer and sets pending=1 on the next cycle.
  - A further load while pending overwrites the shadow buffer; the last one wins.
  - At frame end with pending=1, the shadow buffer is copied to the active buffer and pending clears. The new frame starts with digit 0 of the next frame.
  - load coincident with frame end: the values on the inputs that cycle go straight to the active buffer, and pending is 0 afterwards.
- Blink: the frame counter increments at each frame end. When it reaches BLINK_FRAMES-1 it wraps to 0 and the blink phase toggles.
- The FSM free-runs; load never stalls or resets scanning.
- rst_n asserted mid-frame forces the reset state immediately. After release, scanning restarts at digit 0 in SHOW.

Test Plan:
- Reset/dark: SCAN_DIV=4, GUARD_CYC=1. Hold rst_n=0 for 3 cycles, release, run 40 cycles with no load -> sel=4'b1111 and lout=8'hFF throughout; frame_tick pulses every 20 cycles (first on cycle 20 after release).
- Scan order/decode: load data=16'h3210, dp=4'b0100, blank=0, blink=0 during frame 1 -> pending=1 until frame 1 end. In frame 2:
  - d0: sel=1110, lout=0000_0011 for 4 cycles.
  - then 1 guard cycle with sel=1111.
  - d1: sel=1101, lout=1001_1111.
  - d2: sel=1011, lout=0010_0100.
  - d3: sel=0111, lout=0000_1101.
- No tearing: load data=16'hFFFF while d=1 is shown -> digits 1..3 of the current frame still show the old values; the FFFF patterns (lout=0111_0001) appear only from the next frame's d0.
- Coincident load: assert load on the exact frame_tick cycle with data=16'hA5A5 -> the next frame shows 5,A,5,A on d0..d3 (d0=5, d1=A, d2=5, d3=A); pending stays 0.
- Blink: BLINK_FRAMES=2, blink=4'b0010, data=16'h8888 -> digit 1 is dark (sel=1111) in frames 2-3, lit in frames 0-1 and 4-5; other digits are always lit with lout=0000_0001.
- Mid-frame reset: pulse rst_n low during d=2 -> sel=1111 and lout=FF immediately; the active buffer is back to blank; after reset the first pending load appears from d0.
